// File: rtl/gpio_bus_regs.sv
// GPIO register front end: bus handshake, pin direction/output regs,
// input resync, per-pin edge detect, level irq.
//
// Ports:
//   clk, reset        : rising-edge clock, async active-high reset
//   req_valid/ready   : request handshake (we, addr, wdata)
//   resp_valid/ready  : response handshake (rdata, err)
//   gpio_dir/out      : to pad block, 1 = pin driven
//   gpio_in           : from pad block, already registered once
//   irq               : registered level interrupt
module gpio_bus_regs #(
  parameter int N = 28
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         req_valid,
  output logic         req_ready,
  input  logic         req_we,
  input  logic [5:0]   req_addr,
  input  logic [31:0]  req_wdata,
  output logic         resp_valid,
  input  logic         resp_ready,
  output logic [31:0]  resp_rdata,
  output logic         resp_err,
  output logic [N-1:0] gpio_dir,
  output logic [N-1:0] gpio_out,
  input  logic [N-1:0] gpio_in,
  output logic         irq
);

  localparam logic [3:0] IDX_DIR  = 4'd0;
  localparam logic [3:0] IDX_OUT  = 4'd1;
  localparam logic [3:0] IDX_SET  = 4'd2;
  localparam logic [3:0] IDX_CLR  = 4'd3;
  localparam logic [3:0] IDX_TGL  = 4'd4;
  localparam logic [3:0] IDX_IN   = 4'd5;
  localparam logic [3:0] IDX_EN   = 4'd6;
  localparam logic [3:0] IDX_POL  = 4'd7;
  localparam logic [3:0] IDX_STAT = 4'd8;

  typedef enum logic {
    S_IDLE,
    S_RESP
  } state_t;

  state_t state_q, state_d;

  logic [N-1:0] dir_q, dir_d;
  logic [N-1:0] out_q, out_d;
  logic [N-1:0] en_q, en_d;
  logic [N-1:0] pol_q, pol_d;
  logic [N-1:0] stat_q, stat_d;
  logic [N-1:0] sync_q, prev_q;
  logic         irq_q, irq_d;

  logic [31:0]  rdata_q, rdata_d;
  logic         err_q, err_d;

  logic         accept;
  logic         hit;
  logic [3:0]   idx;
  logic [N-1:0] wd;
  logic [N-1:0] w1c;
  logic [N-1:0] edge_set;
  logic [31:0]  rd_mux;

  // Handshake FSM
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    req_ready  = 1'b0;
    resp_valid = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        req_ready = 1'b1;
        if (req_valid) state_d = S_RESP;
      end
      S_RESP: begin
        resp_valid = 1'b1;
        req_ready  = resp_ready;
        // Back-to-back: a fresh accept keeps us in RESP.
        if (resp_ready && !req_valid) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  assign accept = req_valid && req_ready;

  // Address decode: word aligned and not past the last register.
  assign idx = req_addr[5:2];
  assign hit = (req_addr[1:0] == 2'b00) && (req_addr <= 6'h20);
  assign wd  = req_wdata[N-1:0];

  // A pin raises status only while it is an input.
  assign edge_set = ~dir_q &
                    ((pol_q & sync_q & ~prev_q) |
                     (~pol_q & ~sync_q & prev_q));

  // Register writes
  always_comb begin
    dir_d = dir_q;
    out_d = out_q;
    en_d  = en_q;
    pol_d = pol_q;
    w1c   = '0;
    if (accept && req_we && hit) begin
      case (idx)
        IDX_DIR:  dir_d = wd;
        IDX_OUT:  out_d = wd;
        IDX_SET:  out_d = out_q | wd;
        IDX_CLR:  out_d = out_q & ~wd;
        IDX_TGL:  out_d = out_q ^ wd;
        IDX_EN:   en_d  = wd;
        IDX_POL:  pol_d = wd;
        IDX_STAT: w1c   = wd;
        default:  ;
      endcase
    end
    // Set applied after clear so a same-cycle edge wins.
    stat_d = (stat_q & ~w1c) | edge_set;
    irq_d  = |(stat_q & en_q);
  end

  // Read mux; write-only and unmapped words read 0.
  always_comb begin
    rd_mux = '0;
    case (idx)
      IDX_DIR:  rd_mux = 32'(dir_q);
      IDX_OUT:  rd_mux = 32'(out_q);
      IDX_IN:   rd_mux = 32'(sync_q);
      IDX_EN:   rd_mux = 32'(en_q);
      IDX_POL:  rd_mux = 32'(pol_q);
      IDX_STAT: rd_mux = 32'(stat_q);
      default:  rd_mux = '0;
    endcase
  end

  // Response fields load only on accept, so they hold under stall.
  always_comb begin
    rdata_d = rdata_q;
    err_d   = err_q;
    if (accept) begin
      err_d   = !hit;
      rdata_d = (hit && !req_we) ? rd_mux : 32'd0;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      dir_q   <= '0;
      out_q   <= '0;
      en_q    <= '0;
      pol_q   <= '0;
      stat_q  <= '0;
      sync_q  <= '0;
      prev_q  <= '0;
      irq_q   <= 1'b0;
      rdata_q <= '0;
      err_q   <= 1'b0;
    end else begin
      dir_q   <= dir_d;
      out_q   <= out_d;
      en_q    <= en_d;
      pol_q   <= pol_d;
      stat_q  <= stat_d;
      sync_q  <= gpio_in;
      prev_q  <= sync_q;
      irq_q   <= irq_d;
      rdata_q <= rdata_d;
      err_q   <= err_d;
    end
  end

  assign gpio_dir   = dir_q;
  assign gpio_out   = out_q;
  assign irq        = irq_q;
  assign resp_rdata = rdata_q;
  assign resp_err   = err_q;

endmodule

// File: doc/gpio_bus_regs.md
# gpio_bus_regs

Memory-mapped register front end for the 28-pin GPIO pad block. Accepts single-beat reads/writes from the CPU data bus over a valid/ready request/response handshake. Drives the pad block's per-pin direction and output-data vectors, and takes back its registered input vector. Adds a second synchronizer stage, per-pin edge detection and a level interrupt to the CPU.

## Interface
- `N`, 28: number of GPIO pins. Legal range is 1..32; unused upper data bits read 0.
- `clk` input 1: system clock. All logic is rising-edge.
- `reset` input 1: asynchronous, active-high.
- `req_valid` input 1: bus request present.
- `req_ready` output 1: request accepted when `req_valid && req_ready`.
- `req_we` input 1: 1 = write, 0 = read.
- `req_addr` input 6: byte address.
- `req_wdata` input 32: write data.
- `resp_valid` output 1: response present.
- `resp_ready` input 1: response consumed when `resp_valid && resp_ready`.
- `resp_rdata` output 32: read data. 0 for writes and errors.
- `resp_err` output 1: unmapped or misaligned access.
- `gpio_dir` output N: to pad block. 1 = pin driven.
- `gpio_out` output N: to pad block output data.
- `gpio_in` input N: from pad block. Already registered once in the pad block.
- `irq` output 1: level interrupt, registered.

## Operation
- **Register map** (byte offsets):
  - 0x00 DIR, rw.
  - 0x04 OUT, rw.
  - 0x08 OUT_SET, wo: write 1s to set OUT bits.
  - 0x0C OUT_CLR, wo: write 1s to clear OUT bits.
  - 0x10 OUT_TGL, wo: write 1s to invert OUT bits.
  - 0x14 IN, ro: synchronized pin state.
  - 0x18 IRQ_EN, rw.
  - 0x1C IRQ_POL, rw: 1 = rising edge, 0 = falling edge.
  - 0x20 IRQ_STAT: write-1-to-clear.
- **Write-only registers** read as 0 without error.
- **Writes to read-only registers** (IN) are ignored without error.
- **Errors:** `req_addr[1:0] != 0`, or any address above 0x20, sets `resp_err` = 1 and has no side effects.
- **Input synchronizer:** `sync_q <= gpio_in` every cycle; `prev_q <= sync_q` every cycle. IN reads return `sync_q`.
- **Edge detect**, per bit i:
  - Condition is `!gpio_dir[i]`, plus either `(IRQ_POL[i] && sync_q[i] && !prev_q[i])` or `(!IRQ_POL[i] && !sync_q[i] && prev_q[i])`.
  - When the condition holds, set `IRQ_STAT[i]`.
  - Output pins never raise status.
- **Simultaneous set and W1C clear** on the same bit in the same cycle: set wins, and the bit stays 1.
- **Interrupt output:** `irq <= |(IRQ_STAT & IRQ_EN)`, registered.
- **Handshake FSM** with two states:
  - IDLE: `req_ready` = 1, `resp_valid` = 0. On accept, perform the register write/read-sample and go to RESP.
  - RESP: `resp_valid` = 1, `req_ready` = `resp_ready`. On `resp_ready`, either go to IDLE, or accept a new request in the same cycle and stay in RESP (back-to-back).
  - Response fields hold stable while `resp_valid && !resp_ready`.
- **Reset values:**
  - DIR, OUT, IRQ_EN, IRQ_POL, IRQ_STAT = 0.
  - `sync_q`, `prev_q` = 0.
  - `irq` = 0, `resp_valid` = 0, `resp_err` = 0, `resp_rdata` = 0.
  - FSM = IDLE, so `req_ready` = 1 after reset deasserts.
  - All pins come up as inputs.
- **Reset mid-transaction:** a pending response is dropped and no write completes.

## Timing
- **Write latency:** data accepted at edge k appears on `gpio_dir`/`gpio_out` after edge k. The response is valid in the cycle after edge k.
- **Read data** is sampled at the accept edge. `resp_rdata` is valid in the following cycle.
- **Pin-to-IN latency:** the pad flop plus `sync_q` gives 2 edges from pin change to IN visibility.
- **Pin-to-irq latency:** pad flop, `sync_q`, STAT set, then `irq` register gives 4 edges.
- **Throughput:** one transaction per cycle while `resp_ready` is held 1.

## Test plan
- **Reset state:** assert `reset` mid-response, then release. Required: `gpio_dir` = 0, `gpio_out` = 0, `irq` = 0, `resp_valid` = 0, `req_ready` = 1. A read of DIR returns 0.
- **Output path:**
  - Stimulus: write DIR = 0x000000F, write OUT = 0x0000005, write OUT_SET = 0x2, write OUT_CLR = 0x1, write OUT_TGL = 0x8.
  - Required: `gpio_out` = 0x000000E. Reading OUT returns 0x0000000E.
- **Input sync:** with DIR = 0, drive `gpio_in` = 0xA5A5A5A. Required: the IN read returns 0x0A5A5A5A once 2+ edges have passed, and not earlier.
- **Edge interrupt:**
  - Stimulus: IRQ_EN = 0x1, IRQ_POL = 0x1; bit 0 goes 0→1. Required: `irq` = 1 four edges later, and IRQ_STAT = 0x1.
  - Stimulus: a W1C write of 0x1. Required: `irq` = 0.
  - Stimulus: a falling edge on bit 0 with POL = 1. Required: no set.
  - Stimulus: a W1C write issued in the same cycle as a new rising edge. Required: the bit stays 1.
- **Output pins masked:** with DIR[3] = 1, toggle `gpio_in[3]`. Required: IRQ_STAT[3] stays 0.
- **Bus errors and backpressure:**
  - Stimulus: read 0x02. Required: `resp_err` = 1, `resp_rdata` = 0. Stimulus: write 0x24. Required: `resp_err` = 1 and no register changes.
  - Stimulus: hold `resp_ready` = 0 for 3 cycles. Required: `resp_*` stable and `req_ready` = 0 throughout.
  - Stimulus: back-to-back reads with `resp_ready` = 1. Required: one response per cycle.
